// File: rtl/module_operand_entry_fsm_pkg.sv
// Shared types and constants for the keypad operand-entry controller.
package module_operand_entry_fsm_pkg;

   localparam int unsigned KEY_W   = 4;
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      WAIT_A = 3'd0,
      CONF_A = 3'd1,
      WAIT_B = 3'd2,
      CONF_B = 3'd3,
      BUSY   = 3'd4
   } state_e;

   localparam logic [PHASE_W-1:0] PH_A    = 2'd0;
   localparam logic [PHASE_W-1:0] PH_B    = 2'd1;
   localparam logic [PHASE_W-1:0] PH_BUSY = 2'd2;

   localparam logic [KEY_W-1:0] ENTER_CODE_DEF = 4'hE;
   localparam logic [KEY_W-1:0] CLEAR_CODE_DEF = 4'hF;
   localparam int unsigned      DIGIT_MAX_DEF  = 9;

   // Status encoding reported for each controller state.
   function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
      logic [PHASE_W-1:0] ph;
      ph = PH_A;
      case (s)
         WAIT_A, CONF_A: ph = PH_A;
         WAIT_B, CONF_B: ph = PH_B;
         BUSY:           ph = PH_BUSY;
         default:        ph = PH_A;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/module_operand_entry_fsm_if.sv
// Keypad/arith-unit side bus of the operand-entry controller.
interface module_operand_entry_fsm_if;
   import module_operand_entry_fsm_pkg::*;

   logic               key_valid;
   logic [KEY_W-1:0]   key_code;
   logic               op_done;
   logic [KEY_W-1:0]   num;
   logic               load_a;
   logic               load_b;
   logic               start;
   logic               clr;
   logic [PHASE_W-1:0] phase;

   modport master (
      output key_valid, key_code, op_done,
      input  num, load_a, load_b, start, clr, phase
   );

   modport slave (
      input  key_valid, key_code, op_done,
      output num, load_a, load_b, start, clr, phase
   );
endinterface

// File: rtl/module_operand_entry_fsm_key_pulse.sv
// Rising-edge detector on key_valid: one key_press per keypad press.
module module_key_pulse (
   input  logic clk,
   input  logic rst,
   input  logic key_valid,
   output logic key_press
);
   logic key_valid_d;
   logic key_valid_q;

   always_comb begin
      key_valid_d = key_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_valid_q <= 1'b0;
      else     key_valid_q <= key_valid_d;
   end

   assign key_press = key_valid & ~key_valid_q;
endmodule

// File: rtl/module_operand_entry_fsm.sv
// Turns keypad presses into operand load strobes and a start pulse.
// Build option OPERAND_HEX_EN: codes 0x0-0xD are accepted as operand digits.
module module_operand_entry_fsm
   import module_operand_entry_fsm_pkg::*;
#(
   parameter logic [KEY_W-1:0] ENTER_CODE = ENTER_CODE_DEF,
   parameter logic [KEY_W-1:0] CLEAR_CODE = CLEAR_CODE_DEF,
   parameter int unsigned      DIGIT_MAX  = DIGIT_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   module_operand_entry_fsm_if.slave bus
);

   logic key_press;
   logic is_clear;
   logic is_enter;
   logic is_digit;

   state_e             state_d, state_q;
   logic [KEY_W-1:0]   num_d, num_q;
   logic               load_a_d, load_a_q;
   logic               load_b_d, load_b_q;
   logic               start_d, start_q;
   logic               clr_d, clr_q;
   logic [PHASE_W-1:0] phase_d, phase_q;

   module_key_pulse u_key_pulse (
      .clk       (clk),
      .rst       (rst),
      .key_valid (bus.key_valid),
      .key_press (key_press)
   );

   // Command codes win over the digit class.
   always_comb begin
      is_clear = (bus.key_code == CLEAR_CODE);
      is_enter = !is_clear && (bus.key_code == ENTER_CODE);
`ifdef OPERAND_HEX_EN
      is_digit = !is_clear && !is_enter && (bus.key_code <= 4'hD);
`else
      is_digit = !is_clear && !is_enter && (bus.key_code <= KEY_W'(DIGIT_MAX));
`endif
   end

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      load_a_d = 1'b0;
      load_b_d = 1'b0;
      start_d  = 1'b0;
      clr_d    = 1'b0;

      case (state_q)
         WAIT_A, CONF_A: begin
            if (key_press) begin
               if (is_clear) begin
                  clr_d   = 1'b1;
                  state_d = WAIT_A;
               end else if (is_enter) begin
                  if (state_q == CONF_A) state_d = WAIT_B;
               end else if (is_digit) begin
                  num_d    = bus.key_code;
                  load_a_d = 1'b1;
                  state_d  = CONF_A;
               end
            end
         end
         WAIT_B, CONF_B: begin
            if (key_press) begin
               if (is_clear) begin
                  clr_d   = 1'b1;
                  state_d = WAIT_A;
               end else if (is_enter) begin
                  if (state_q == CONF_B) begin
                     start_d = 1'b1;
                     state_d = BUSY;
                  end
               end else if (is_digit) begin
                  num_d    = bus.key_code;
                  load_b_d = 1'b1;
                  state_d  = CONF_B;
               end
            end
         end
         // Presses during an operation are dropped, even on the op_done cycle.
         BUSY: begin
            if (bus.op_done) state_d = WAIT_A;
         end
         default: state_d = WAIT_A;
      endcase

      phase_d = phase_of(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= WAIT_A;
         num_q    <= '0;
         load_a_q <= 1'b0;
         load_b_q <= 1'b0;
         start_q  <= 1'b0;
         clr_q    <= 1'b0;
         phase_q  <= PH_A;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         load_a_q <= load_a_d;
         load_b_q <= load_b_d;
         start_q  <= start_d;
         clr_q    <= clr_d;
         phase_q  <= phase_d;
      end
   end

   assign bus.num    = num_q;
   assign bus.load_a = load_a_q;
   assign bus.load_b = load_b_q;
   assign bus.start  = start_q;
   assign bus.clr    = clr_q;
   assign bus.phase  = phase_q;

endmodule
